sprite_dma: RTL and testbench

- Agnus-side sprite DMA sequencer: the writer end of the sprite register interface that Denise's sprite shifters receive.
- Fetches sprite control and data words from chip RAM in fixed per-line sprite slots.
- Presents each fetched word on the register bus as a write to SPRxPOS/SPRxCTL/SPRxDATA/SPRxDATB (base $140).
- Tracks per-sprite pointers and vertical start/stop for all 8 sprites.

---
 rtl/sprite_dma.sv | 102 ++++++++++
 tb/tb_sprite_dma.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma.sv
// sprite_dma: Agnus sprite DMA sequencer driving the SPRxPOS/CTL/DATA/DATB register bus
module sprite_dma #(
  parameter logic [8:0] VBSTOP   = 9'h019,
  parameter logic [7:0] SLOTBASE = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        dmaen,
  input  logic [8:1]  regaddress_in,
  input  logic        reg_wr,
  input  logic [15:0] reg_data_in,
  input  logic [15:0] chip_data,
  output logic        dma,
  output logic [20:1] address_out,
  output logic [8:1]  regaddress_out
);
  typedef enum logic [1:0] {IDLE, FETCHCTL, WAITSTART, ACTIVE} state_t;
  state_t      state    [8];
  state_t      state_nx [8];
  logic [20:1] ptr      [8];
  logic [8:0]  vstart   [8];
  logic [8:0]  vstop    [8];
  logic [7:0]  pos_zero;
  logic [7:0]  rel;
  logic [2:0]  sp;
  logic [1:0]  rsel;
  logic        slot_b;
  logic        in_slot;
  logic        fetch;
  logic        ptr_wr;
  logic        pos_wr;
  logic [2:0]  ptr_n;
  logic [2:0]  pos_n;
  logic        unused_bits;
  assign rel            = hpos[8:1] - SLOTBASE;
  assign sp             = rel[4:2];
  assign slot_b         = rel[1];
  assign in_slot        = !hpos[0] && rel[7:5] == 3'd0 && !rel[0];
  assign fetch          = in_slot && dmaen && (state[sp] == FETCHCTL || state[sp] == ACTIVE);
  assign rsel           = state[sp] == FETCHCTL ? {1'b0, slot_b} : {1'b1, !slot_b};
  assign dma            = fetch;
  assign address_out    = fetch ? ptr[sp] : '0;
  assign regaddress_out = fetch ? {3'b101, sp, rsel} : 8'hFF;
  assign ptr_wr         = reg_wr && regaddress_in[8:5] == 4'b1001;
  assign ptr_n          = regaddress_in[4:2];
  assign pos_wr         = reg_wr && regaddress_in[8:6] == 3'b101;
  assign pos_n          = regaddress_in[5:3];
  assign unused_bits    = reg_data_in[0];
  // next state per sprite: frame restart, line-start checks, end of the control fetch
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      state_nx[i] = state[i];
      if (hpos == 9'd0)
        state_nx[i] = vpos == VBSTOP ? FETCHCTL
                    : state[i] == WAITSTART ? (vpos == vstop[i] ? FETCHCTL : vpos == vstart[i] ? ACTIVE : WAITSTART)
                    : (state[i] == ACTIVE && vpos == vstop[i]) ? FETCHCTL : state[i];
      else if (fetch && sp == 3'(i) && rsel == 2'b01)
        state_nx[i] = (pos_zero[i] && chip_data == 16'h0) ? IDLE : WAITSTART;
    end
  end
  // sprite state registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      state[i] <= reset ? IDLE : state_nx[i];
  end
  // pointers and vertical limits; a CPU pointer write cancels a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        ptr[i]    <= '0;
        vstart[i] <= '0;
        vstop[i]  <= '0;
      end
      pos_zero <= '0;
    end else begin
      if (fetch && !(ptr_wr && ptr_n == sp))
        ptr[sp] <= ptr[sp] + 20'd1;
      if (fetch && rsel == 2'b00) begin
        vstart[sp][7:0] <= chip_data[15:8];
        pos_zero[sp]    <= chip_data == 16'h0;
      end
      if (fetch && rsel == 2'b01) begin
        vstop[sp][7:0] <= chip_data[15:8];
        vstart[sp][8]  <= chip_data[2];
        vstop[sp][8]   <= chip_data[1];
      end
      if (ptr_wr && !regaddress_in[1])
        ptr[ptr_n][20:16] <= reg_data_in[4:0];
      if (ptr_wr && regaddress_in[1])
        ptr[ptr_n][15:1] <= reg_data_in[15:1];
      if (pos_wr && regaddress_in[2:1] == 2'b00)
        vstart[pos_n][7:0] <= reg_data_in[15:8];
      if (pos_wr && regaddress_in[2:1] == 2'b01) begin
        vstop[pos_n][7:0] <= reg_data_in[15:8];
        vstart[pos_n][8]  <= reg_data_in[2];
        vstop[pos_n][8]   <= reg_data_in[1];
      end
    end
  end
endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: directed bench with a slot-level sprite DMA model checked every cycle
module tb_sprite_dma;
  logic        clk;
  logic        reset;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        dmaen;
  logic [7:0]  regaddress_in;
  logic        reg_wr;
  logic [15:0] reg_data_in;
  logic [15:0] chip_data;
  logic        dma;
  logic [19:0] address_out;
  logic [7:0]  regaddress_out;
  logic [15:0] mem [8192];
  int errors = 0;
  int checks = 0;
  logic chk_en = 0;
  localparam int S_IDLE = 0, S_CTL = 1, S_WAIT = 2, S_ACT = 3;
  int          m_st  [8];
  logic [19:0] m_ptr [8];
  logic [8:0]  m_vs  [8];
  logic [8:0]  m_ve  [8];
  logic [15:0] m_pos [8];
  typedef struct { int h; logic [19:0] a; logic [7:0] r; } ev_t;
  ev_t ev [$];

  sprite_dma dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .dmaen(dmaen),
    .regaddress_in(regaddress_in), .reg_wr(reg_wr), .reg_data_in(reg_data_in),
    .chip_data(chip_data), .dma(dma), .address_out(address_out), .regaddress_out(regaddress_out)
  );

  assign chip_data = mem[address_out[12:0]];

  initial clk = 0;
  always #5 clk = ~clk;

  // model: slot positions from the colour-clock arithmetic, states updated on each cycle
  always @(negedge clk) begin : cmp
    logic        e_dma;
    logic [19:0] e_addr;
    logic [7:0]  e_reg;
    int          e_n;
    int          e_r;
    int          cpn;
    int          k;
    int          r;
    e_dma = 0; e_addr = 0; e_reg = 8'hFF; e_n = -1; e_r = 0;
    for (int n = 0; n < 8; n++)
      for (int b = 0; b < 2; b++)
        if (int'(hpos) == 2 * (21 + 4 * n + 2 * b) && dmaen && (m_st[n] == S_CTL || m_st[n] == S_ACT)) begin
          e_n = n;
          e_r = (m_st[n] == S_CTL) ? b : 3 - b;
          e_dma = 1;
          e_addr = m_ptr[n];
          e_reg = 8'(160 + 4 * n + e_r);
        end
    if (chk_en) begin
      checks++;
      if (dma !== e_dma || address_out !== e_addr || regaddress_out !== e_reg) begin
        errors++;
        $display("FAIL bus h=%0h v=%0h: got dma=%b addr=%h reg=%h, required dma=%b addr=%h reg=%h",
                 hpos, vpos, dma, address_out, regaddress_out, e_dma, e_addr, e_reg);
      end
      if (dma === 1'b1) ev.push_back('{int'(hpos), address_out, regaddress_out});
    end
    if (reset) begin
      for (int n = 0; n < 8; n++) begin
        m_st[n] = S_IDLE; m_ptr[n] = 0; m_vs[n] = 0; m_ve[n] = 0; m_pos[n] = 0;
      end
    end else begin
      if (hpos == 0)
        for (int n = 0; n < 8; n++) begin
          if (vpos == 9'h019) m_st[n] = S_CTL;
          else if (m_st[n] == S_WAIT) m_st[n] = (vpos == m_ve[n]) ? S_CTL : (vpos == m_vs[n]) ? S_ACT : S_WAIT;
          else if (m_st[n] == S_ACT && vpos == m_ve[n]) m_st[n] = S_CTL;
        end
      cpn = (reg_wr && regaddress_in >= 8'h90 && regaddress_in <= 8'h9F) ? (int'(regaddress_in) - 144) / 2 : -1;
      if (e_n >= 0) begin
        if (cpn != e_n) m_ptr[e_n] = m_ptr[e_n] + 20'd1;
        if (e_r == 0) begin
          m_vs[e_n][7:0] = chip_data[15:8];
          m_pos[e_n] = chip_data;
        end
        if (e_r == 1) begin
          m_ve[e_n][7:0] = chip_data[15:8];
          m_vs[e_n][8] = chip_data[2];
          m_ve[e_n][8] = chip_data[1];
          m_st[e_n] = (m_pos[e_n] == 0 && chip_data == 0) ? S_IDLE : S_WAIT;
        end
      end
      if (cpn >= 0)
        m_ptr[cpn] = (regaddress_in % 2 == 0) ? ((m_ptr[cpn] & 20'h07FFF) | (20'(reg_data_in & 16'h001F) << 15))
                                              : ((m_ptr[cpn] & 20'hF8000) | 20'(reg_data_in >> 1));
      if (reg_wr && regaddress_in >= 8'hA0 && regaddress_in <= 8'hBF) begin
        k = (int'(regaddress_in) - 160) / 4;
        r = (int'(regaddress_in) - 160) % 4;
        if (r == 0) m_vs[k][7:0] = reg_data_in[15:8];
        if (r == 1) begin
          m_ve[k][7:0] = reg_data_in[15:8];
          m_vs[k][8] = reg_data_in[2];
          m_ve[k][8] = reg_data_in[1];
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  function automatic int nev(input int spr);
    int c = 0;
    foreach (ev[i]) if (spr < 0 || int'(ev[i].r[4:2]) == spr) c++;
    return c;
  endfunction

  function automatic int nev_after(input int h);
    int c = 0;
    foreach (ev[i]) if (ev[i].h > h) c++;
    return c;
  endfunction

  task automatic ev_chk(input string nm, input int spr, input int idx, input int eh,
                        input logic [19:0] ea, input logic [7:0] er);
    int k = 0;
    logic found = 0;
    foreach (ev[i])
      if (int'(ev[i].r[4:2]) == spr) begin
        if (k == idx && !found) begin
          found = 1;
          lit(nm, {12'(ev[i].h), ev[i].a, ev[i].r}, {12'(eh), ea, er});
        end
        k++;
      end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: got no fetch, required h=%0h addr=%h reg=%h", nm, eh, ea, er);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1; reg_wr = 0; dmaen = 1; hpos = 9'h070; vpos = 9'h100;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    hpos = 9'h070; vpos = 9'h100; reg_wr = 1; regaddress_in = a; reg_data_in = d;
    @(posedge clk); #1 reg_wr = 0;
  endtask

  task automatic run_line(input logic [8:0] v, input logic en, input int wr_h,
                          input logic [7:0] wa, input logic [15:0] wd, input int rst_h);
    ev.delete();
    for (int h = 0; h < 128; h++) begin
      @(posedge clk); #1;
      hpos = 9'(h); vpos = v; dmaen = en; reset = (h == rst_h);
      reg_wr = (h == wr_h); regaddress_in = wa; reg_data_in = wd;
      if (rst_h >= 0 && h == rst_h + 1) begin
        #1;
        lit("rst_next_dma", 64'(dma), 64'd0);
        lit("rst_next_reg", 64'(regaddress_out), 64'hFF);
      end
    end
  endtask

  task automatic set_ptr0;
    cpu_wr(8'h90, 16'h0000);
    cpu_wr(8'h91, 16'h2000);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_st[i] = S_IDLE; m_ptr[i] = 0; m_vs[i] = 0; m_ve[i] = 0; m_pos[i] = 0;
    end
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[13'h1000] = 16'h3040; mem[13'h1001] = 16'h3200;
    mem[13'h1002] = 16'hAAAA; mem[13'h1003] = 16'h5555;
    mem[13'h1004] = 16'h0F0F; mem[13'h1005] = 16'hF0F0;
    reset = 1; hpos = 9'h070; vpos = 9'h100; dmaen = 1;
    reg_wr = 0; regaddress_in = 8'h00; reg_data_in = 16'h0000;

    do_reset;
    @(posedge clk); #1 hpos = 9'h02A; vpos = 9'h100; dmaen = 1;
    #1;
    lit("reset_dma", 64'(dma), 64'd0);
    lit("reset_addr", 64'(address_out), 64'd0);
    lit("reset_reg", 64'(regaddress_out), 64'hFF);

    set_ptr0;
    run_line(9'h019, 1, -1, 8'h00, 16'h0, -1);
    lit("l19_count", 64'(nev(0)), 64'd2);
    ev_chk("l19_pos", 0, 0, 'h2A, 20'h01000, 8'hA0);
    ev_chk("l19_ctl", 0, 1, 'h2E, 20'h01001, 8'hA1);
    run_line(9'h030, 1, -1, 8'h00, 16'h0, -1);
    ev_chk("l30_datb", 0, 0, 'h2A, 20'h01002, 8'hA3);
    ev_chk("l30_data", 0, 1, 'h2E, 20'h01003, 8'hA2);
    run_line(9'h031, 1, -1, 8'h00, 16'h0, -1);
    ev_chk("l31_datb", 0, 0, 'h2A, 20'h01004, 8'hA3);
    ev_chk("l31_data", 0, 1, 'h2E, 20'h01005, 8'hA2);
    run_line(9'h032, 1, -1, 8'h00, 16'h0, -1);
    ev_chk("l32_pos", 0, 0, 'h2A, 20'h01006, 8'hA0);
    ev_chk("l32_ctl", 0, 1, 'h2E, 20'h01007, 8'hA1);
    run_line(9'h033, 1, -1, 8'h00, 16'h0, -1);
    lit("idle_l33", 64'(nev(0)), 64'd0);
    run_line(9'h050, 1, -1, 8'h00, 16'h0, -1);
    lit("idle_l50", 64'(nev(0)), 64'd0);

    do_reset;
    set_ptr0;
    run_line(9'h019, 1, -1, 8'h00, 16'h0, -1);
    run_line(9'h030, 1, -1, 8'h00, 16'h0, -1);
    run_line(9'h031, 0, -1, 8'h00, 16'h0, -1);
    lit("dis_l31_count", 64'(nev(-1)), 64'd0);
    run_line(9'h032, 1, -1, 8'h00, 16'h0, -1);
    ev_chk("dis_l32_pos", 0, 0, 'h2A, 20'h01004, 8'hA0);
    ev_chk("dis_l32_ctl", 0, 1, 'h2E, 20'h01005, 8'hA1);

    do_reset;
    cpu_wr(8'h96, 16'h0000);
    cpu_wr(8'h97, 16'h0A00);
    run_line(9'h019, 1, 'h42, 8'h97, 16'h2000, -1);
    ev_chk("cpu_pos3", 3, 0, 'h42, 20'h00500, 8'hAC);
    ev_chk("cpu_ctl3", 3, 1, 'h46, 20'h01000, 8'hAD);

    do_reset;
    set_ptr0;
    run_line(9'h019, 1, -1, 8'h00, 16'h0, 'h2E);
    lit("rst_after_count", 64'(nev_after('h2E)), 64'd0);
    run_line(9'h030, 1, -1, 8'h00, 16'h0, -1);
    lit("rst_idle_l30", 64'(nev(-1)), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
